// File: rtl/rvtest_pkg.sv
// Shared types and constants for the riscv-tests regression sequencer.
// FSM states, per-test result codes and the TOHOST pass word.
package rvtest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_NEXT,
    ST_DONE
  } state_t;

  typedef logic [1:0] res_t;

  localparam res_t RES_PASS = 2'b00;
  localparam res_t RES_FAIL = 2'b01;
  localparam res_t RES_TMO  = 2'b10;
  localparam res_t RES_NONE = 2'b11;

  localparam int TOHOST_PASS = 1;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rvtest_watchdog.sv
// Clear/enable counter with a compare-to-limit expire flag.
// Times both the core reset hold and the per-test run budget.
module rvtest_watchdog #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic         exp_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign exp_o = en_i && (cnt_q == lim_i);

endmodule

// File: rtl/rvtest_sequencer.sv
// Runs NUM_TESTS riscv-tests images back to back and tallies results.
// Optional per-test result log: define RVTEST_RESULT_LOG_EN.
module rvtest_sequencer
  import rvtest_pkg::*;
#(
  parameter int                NUM_TESTS      = 38,
  parameter int                XLEN           = 32,
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 'h1000,
  parameter int                RESET_CYCLES   = 4,
  parameter int                TIMEOUT_CYCLES = 100000,
  localparam int               CW = $clog2(NUM_TESTS + 1)
) (
  input  logic              sys_clk,
  input  logic              sys_res,
  input  logic              start,
  output logic              core_res,
  output logic              load_req,
  input  logic              load_ack,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [CW-1:0]     test_idx,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt,
  output logic [CW-1:0]     tmo_cnt,
  output logic [XLEN-1:0]   last_code
`ifdef RVTEST_RESULT_LOG_EN
  ,
  input  logic [CW-1:0]     log_idx,
  output logic [1:0]        log_result
`endif
);

  localparam int WW =
    $clog2(max_i(TIMEOUT_CYCLES, RESET_CYCLES) + 1);

  state_t          st_q;
  logic [CW-1:0]   idx_q, pass_q, fail_q, tmo_q;
  logic [XLEN-1:0] code_q;
  logic            busy_q, done_q;

  logic            go, hit, is_pass, is_fail;
  logic            wd_en, wd_clr, wd_exp;
  logic [WW-1:0]   wd_lim;

  assign go = start &&
    (st_q == ST_IDLE || st_q == ST_DONE);

  // Odd TOHOST words end a test; even ones are console traffic
  assign hit = mem_we && (mem_addr == TOHOST_ADDR) &&
    mem_wdata[0];
  assign is_pass = hit &&
    (mem_wdata == XLEN'(TOHOST_PASS));
  assign is_fail = hit && !is_pass;

  assign wd_en  = (st_q == ST_HOLD) || (st_q == ST_RUN);
  assign wd_clr = !wd_en || wd_exp;
  assign wd_lim = (st_q == ST_HOLD) ?
    WW'(RESET_CYCLES - 1) : WW'(TIMEOUT_CYCLES - 1);

  rvtest_watchdog #(.W(WW)) u_wd (
    .clk_i  (sys_clk),
    .rst_ni (sys_res),
    .clr_i  (wd_clr),
    .en_i   (wd_en),
    .lim_i  (wd_lim),
    .exp_o  (wd_exp)
  );

  // Test sequencing FSM with registered status and counters
  always_ff @(posedge sys_clk or negedge sys_res) begin
    if (!sys_res) begin
      st_q   <= ST_IDLE;
      idx_q  <= '0;
      pass_q <= '0;
      fail_q <= '0;
      tmo_q  <= '0;
      code_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (st_q)
        ST_IDLE, ST_DONE: begin
          if (go) begin
            st_q   <= ST_LOAD;
            idx_q  <= '0;
            pass_q <= '0;
            fail_q <= '0;
            tmo_q  <= '0;
            code_q <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_ack)
            st_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (wd_exp)
            st_q <= ST_RUN;
        end
        ST_RUN: begin
          if (is_pass) begin
            pass_q <= pass_q + 1'b1;
            st_q   <= ST_NEXT;
          end else if (is_fail) begin
            fail_q <= fail_q + 1'b1;
            code_q <= mem_wdata;
            st_q   <= ST_NEXT;
          end else if (wd_exp) begin
            tmo_q <= tmo_q + 1'b1;
            st_q  <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (idx_q == CW'(NUM_TESTS - 1)) begin
            st_q   <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
            st_q  <= ST_LOAD;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign core_res  = (st_q != ST_RUN);
  assign load_req  = (st_q == ST_LOAD);
  assign test_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign tmo_cnt   = tmo_q;
  assign last_code = code_q;

`ifdef RVTEST_RESULT_LOG_EN
  // Sized to the full index range so out-of-range reads see RES_NONE
  res_t res_q;
  res_t log_q [2**CW];

  // Latch the outcome in RUN, commit it to the log in NEXT
  always_ff @(posedge sys_clk or negedge sys_res) begin
    if (!sys_res) begin
      res_q <= RES_NONE;
      for (int i = 0; i < 2**CW; i++)
        log_q[i] <= RES_NONE;
    end else if (go) begin
      res_q <= RES_NONE;
      for (int i = 0; i < 2**CW; i++)
        log_q[i] <= RES_NONE;
    end else if (st_q == ST_RUN) begin
      if (is_pass)
        res_q <= RES_PASS;
      else if (is_fail)
        res_q <= RES_FAIL;
      else if (wd_exp)
        res_q <= RES_TMO;
    end else if (st_q == ST_NEXT) begin
      log_q[idx_q] <= res_q;
    end
  end

  assign log_result = log_q[log_idx];
`endif

endmodule

// File: doc/rvtest_sequencer.md
Name: rvtest_sequencer

Overview:
Synthesisable regression sequencer that runs NUM_TESTS riscv-tests images back to back on the core without bench intervention.
- Per test: holds the core in reset, handshakes a memory load, releases the core, then snoops data-bus writes to a TOHOST address to classify the test as pass, fail or timeout.
- Sits beside top, driving its core reset.
- Usable from the simulation bench and on FPGA.

Parameters:
NUM_TESTS, 38, number of test images in the run (>=1)
XLEN, 32, data-bus width
ADDR_W, 32, data-bus address width
TOHOST_ADDR, 32'h0000_1000, snooped completion address
RESET_CYCLES, 4, cycles core_res is held after load_ack
TIMEOUT_CYCLES, 100000, max RUN cycles per test (>=1)

Ports:
sys_clk  in  1  clock
sys_res  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse, begins a run from IDLE/DONE
core_res  out  1  active-high reset to core
load_req  out  1  request loading of image test_idx
load_ack  in  1  loader finished image test_idx
mem_we  in  1  core data-bus write strobe
mem_addr  in  ADDR_W  core data-bus address
mem_wdata  in  XLEN  core data-bus write data
test_idx  out  $clog2(NUM_TESTS+1)  current test index
busy  out  1  run in progress
done  out  1  run finished, held until next start
pass_cnt  out  $clog2(NUM_TESTS+1)  passed tests
fail_cnt  out  $clog2(NUM_TESTS+1)  failed tests
tmo_cnt  out  $clog2(NUM_TESTS+1)  timed-out tests
last_code  out  XLEN  last TOHOST word classified as fail (0 if none)

Behaviour:
- Reset (sys_res=0, async): state IDLE; core_res=1; load_req=0; busy=0; done=0; test_idx=0; all counters 0; last_code=0; watchdog 0.
- States: IDLE, LOAD, HOLD, RUN, NEXT, DONE.
- IDLE/DONE -> LOAD on start.
  - Clear counters, test_idx, last_code.
  - done=0, busy=1.
- LOAD:
  - core_res=1, load_req=1.
  - On load_ack=1: load_req drops next cycle; -> HOLD.
  - load_ack outside LOAD is ignored.
- HOLD:
  - core_res=1 for exactly RESET_CYCLES cycles; -> RUN.
- RUN:
  - core_res=0; watchdog increments every cycle.
  - Exit on a qualifying write (mem_we=1 && mem_addr==TOHOST_ADDR), classified on wdata:
    - wdata==1: pass_cnt+1.
    - wdata[0]==1 && wdata!=1: fail_cnt+1, last_code=wdata (failing subtest = wdata>>1).
    - wdata[0]==0: ignored (console/other); stay in RUN.
  - On pass/fail -> NEXT.
  - When watchdog reaches TIMEOUT_CYCLES-1 without a pass/fail: tmo_cnt+1 -> NEXT.
  - If a qualifying write and the timeout occur in the same cycle, the write wins: classified as pass/fail, no timeout recorded.
- NEXT (1 cycle):
  - core_res=1; watchdog cleared.
  - If test_idx==NUM_TESTS-1: -> DONE. Otherwise test_idx+1 -> LOAD.
- DONE:
  - busy=0, done=1, core_res=1.
  - test_idx holds NUM_TESTS-1.
  - Counters hold.
- Invariant: pass_cnt+fail_cnt+tmo_cnt == tests completed. Counters never wrap (width covers NUM_TESTS).
- start while busy is ignored.
- sys_res low mid-run: immediate return to reset values; the load handshake is abandoned (load_req drops asynchronously).
- All outputs are registered except load_req and core_res, which are decoded from state.

Optional Feature:
RVTEST_RESULT_LOG_EN
- Defined:
  - Adds a NUM_TESTS x 2-bit result memory written in NEXT (00 pass, 01 fail, 10 timeout, 11 not run). All entries are set to 11 on start.
  - Adds ports log_idx (in, test_idx width) and log_result (out, 2), with combinational read.
  - Out-of-range log_idx reads 11.
- Undefined: no memory, no extra ports; counters only.

Decomposition:
- Package rvtest_pkg holds:
  - state enum (IDLE, LOAD, HOLD, RUN, NEXT, DONE)
  - result codes RES_PASS, RES_FAIL, RES_TMO, RES_NONE
  - TOHOST_PASS constant (1)
- One sub-module, rvtest_watchdog: clear/enable/expire counter sized $clog2(TIMEOUT_CYCLES+1), used for both HOLD length and RUN timeout.

Test Plan:
1. NUM_TESTS=3; every test writes 1 to 0x1000 -> done=1, pass_cnt=3, fail_cnt=0, tmo_cnt=0, core_res=1 in DONE.
2. Test 1 writes 0x0000_0007 to TOHOST -> fail_cnt=1, last_code=7; tests 0 and 2 pass.
3. Test writes 0x2 then 0x1 to TOHOST -> the even write is ignored; pass recorded once.
4. TIMEOUT_CYCLES=50, core silent -> exactly 50 RUN cycles before NEXT; tmo_cnt=1.
5. A TOHOST=1 write coincides with the timeout cycle -> pass_cnt+1, tmo_cnt unchanged.
6. sys_res low during RUN of test 1, then start -> counters restart at 0; load_req reasserted for test_idx=0 with core_res=1 throughout LOAD/HOLD. With RVTEST_RESULT_LOG_EN, log_result for untouched entries reads 11.
